usb_rx_bit_ctrl: RTL and testbench

USB_RX_BIT_CTRL -- requirements
Module: usb_rx_bit_ctrl

---
 rtl/usb_rx_pkg.sv | 26 ++
 rtl/usb_rx_bit_ctrl_if.sv | 26 ++
 rtl/flex_counter.sv | 44 ++++
 rtl/usb_rx_bit_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_usb_rx_bit_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive bit controller
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    // Line states encoded as {d_plus, d_minus}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    function automatic line_state_e line_state(input logic dp, input logic dm);
        return line_state_e'({dp, dm});
    endfunction

endpackage

// File: rtl/usb_rx_bit_ctrl_if.sv
// rtl/usb_rx_bit_ctrl_if.sv - line-side and decoded-side signal bundle for usb_rx_bit_ctrl
interface usb_rx_bit_ctrl_if;

    logic       d_plus;
    logic       d_minus;
    logic       bit_strobe;
    logic [7:0] rcv_data;
    logic       byte_rcvd;
    logic       sync_found;
    logic       eop;
    logic       rx_err;
    logic       rcving;

    // Line driver side: presents sampled lines and the bit-centre strobe
    modport master (
        output d_plus, d_minus, bit_strobe,
        input  rcv_data, byte_rcvd, sync_found, eop, rx_err, rcving
    );

    // Receiver side: consumes lines, reports decoded bytes and packet events
    modport slave (
        input  d_plus, d_minus, bit_strobe,
        output rcv_data, byte_rcvd, sync_found, eop, rx_err, rcving
    );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - parameterised up-counter with clear and registered rollover flag
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins, otherwise count up and wrap to 1 after the rollover value
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
        flag_d = (count_d == rollover_val);
    end

    // Count and flag registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign rollover_flag = flag_q;

endmodule

// File: rtl/usb_rx_bit_ctrl.sv
// rtl/usb_rx_bit_ctrl.sv - USB full-speed receive bit controller: NRZI decode, sync, destuff, byte assembly, EOP
module usb_rx_bit_ctrl
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       bit_strobe,
    output logic [7:0] rcv_data,
    output logic       byte_rcvd,
    output logic       sync_found,
    output logic       eop,
    output logic       rx_err,
    output logic       rcving
);

    localparam logic [2:0] STUFF_VAL = 3'(STUFF_LEN);

    rx_state_e   state_q, state_d;
    logic        prev_dp_q, prev_dp_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rcv_data_q, rcv_data_d;
    logic        partial_q, partial_d;
    logic        se0_seen_q, se0_seen_d;
    logic        byte_rcvd_q, byte_rcvd_d;
    logic        sync_found_q, sync_found_d;
    logic        eop_q, eop_d;
    logic        rx_err_q, rx_err_d;
    logic        rcving_q, rcving_d;

    line_state_e ls;
    logic        dec_bit;
    logic [7:0]  shifted;
    logic        ones_inc;
    logic        ones_clr;
    logic        stuff_due;

    assign ls      = line_state(d_plus, d_minus);
    assign dec_bit = (d_plus == prev_dp_q);
    assign shifted = {dec_bit, shift_q[7:1]};

    // Run of decoded 1s inside DATA; held at zero in every other state
    flex_counter #(
        .NUM_CNT_BITS (3)
    ) u_ones_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (ones_clr || (state_q != ST_DATA)),
        .count_enable  (ones_inc),
        .rollover_val  (STUFF_VAL),
        .rollover_flag (stuff_due)
    );

    // Next-state and output decode, evaluated only on bit-centre strobes
    always_comb begin
        state_d      = state_q;
        prev_dp_d    = prev_dp_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rcv_data_d   = rcv_data_q;
        partial_d    = partial_q;
        se0_seen_d   = se0_seen_q;
        byte_rcvd_d  = 1'b0;
        sync_found_d = 1'b0;
        eop_d        = 1'b0;
        rx_err_d     = 1'b0;
        ones_inc     = 1'b0;
        ones_clr     = 1'b0;

        if (bit_strobe) begin
            prev_dp_d = d_plus;
            case (state_q)
                ST_IDLE: begin
                    if (ls == LS_K) begin
                        state_d   = ST_SYNC;
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (ls == LS_SE0) begin
                        state_d   = ST_EOP;
                        partial_d = (bit_cnt_q != 3'd0);
                    end else begin
                        shift_d = shifted;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (shifted == SYNC_BYTE) begin
                                state_d      = ST_DATA;
                                sync_found_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (ls == LS_SE0) begin
                        state_d   = ST_EOP;
                        partial_d = (bit_cnt_q != 3'd0);
                    end else if (stuff_due) begin
                        // Stuffed bit: dropped; a 1 here means the sender broke the stuffing rule
                        ones_clr = 1'b1;
                        if (dec_bit) begin
                            state_d    = ST_ERR;
                            rx_err_d   = 1'b1;
                            se0_seen_d = 1'b0;
                        end
                    end else begin
                        shift_d  = shifted;
                        ones_inc = dec_bit;
                        ones_clr = !dec_bit;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d   = 3'd0;
                            rcv_data_d  = shifted;
                            byte_rcvd_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_EOP: begin
                    if (ls == LS_J) begin
                        state_d  = ST_IDLE;
                        eop_d    = 1'b1;
                        rx_err_d = partial_q;
                    end else if (ls != LS_SE0) begin
                        state_d    = ST_ERR;
                        se0_seen_d = 1'b0;
                    end
                end
                ST_ERR: begin
                    if (ls == LS_SE0) begin
                        se0_seen_d = 1'b1;
                    end else if ((ls == LS_J) && se0_seen_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rcving_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            prev_dp_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            rcv_data_q   <= 8'h00;
            partial_q    <= 1'b0;
            se0_seen_q   <= 1'b0;
            byte_rcvd_q  <= 1'b0;
            sync_found_q <= 1'b0;
            eop_q        <= 1'b0;
            rx_err_q     <= 1'b0;
            rcving_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_dp_q    <= prev_dp_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rcv_data_q   <= rcv_data_d;
            partial_q    <= partial_d;
            se0_seen_q   <= se0_seen_d;
            byte_rcvd_q  <= byte_rcvd_d;
            sync_found_q <= sync_found_d;
            eop_q        <= eop_d;
            rx_err_q     <= rx_err_d;
            rcving_q     <= rcving_d;
        end
    end

    assign rcv_data   = rcv_data_q;
    assign byte_rcvd  = byte_rcvd_q;
    assign sync_found = sync_found_q;
    assign eop        = eop_q;
    assign rx_err     = rx_err_q;
    assign rcving     = rcving_q;

endmodule

// File: tb/tb_usb_rx_bit_ctrl.sv
// tb/tb_usb_rx_bit_ctrl.sv - self-checking bench for usb_rx_bit_ctrl driven from a transmit-side model
module tb_usb_rx_bit_ctrl;

    logic clk = 1'b0;
    logic n_rst;

    usb_rx_bit_ctrl_if bus();

    always #5 clk = ~clk;

    usb_rx_bit_ctrl #(
        .STUFF_LEN (6)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .d_plus     (bus.d_plus),
        .d_minus    (bus.d_minus),
        .bit_strobe (bus.bit_strobe),
        .rcv_data   (bus.rcv_data),
        .byte_rcvd  (bus.byte_rcvd),
        .sync_found (bus.sync_found),
        .eop        (bus.eop),
        .rx_err     (bus.rx_err),
        .rcving     (bus.rcving)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, written by the transmit model
    logic       e_sync = 1'b0, e_byte = 1'b0, e_eop = 1'b0, e_err = 1'b0, e_rcv = 1'b0;
    logic [7:0] e_data = 8'h00;

    // Transmit model state: line level (1 = J), run of 1s since DATA start, last byte, packet-active
    bit         lvl = 1'b1;
    int         run = 0;
    logic [7:0] model_data = 8'h00;
    bit         model_rcv = 1'b0;

    int c_sync = 0, c_byte = 0, c_eop = 0, c_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus pulse tallies for the literal checks
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sync_found", bus.sync_found, e_sync);
            chk("byte_rcvd",  bus.byte_rcvd,  e_byte);
            chk("eop",        bus.eop,        e_eop);
            chk("rx_err",     bus.rx_err,     e_err);
            chk("rcv_data",   bus.rcv_data,   e_data);
            chk("rcving",     bus.rcving,     e_rcv);
            if (bus.sync_found === 1'b1) c_sync++;
            if (bus.byte_rcvd === 1'b1)  c_byte++;
            if (bus.eop === 1'b1)        c_eop++;
            if (bus.rx_err === 1'b1)     c_err++;
        end
    end

    task automatic clr_counts();
        c_sync = 0; c_byte = 0; c_eop = 0; c_err = 0;
    endtask

    // One strobed line sample; pulses are expected for exactly the following cycle
    task automatic line(input logic dp, input logic dm, input bit s, input bit b, input bit e, input bit r);
        @(negedge clk);
        bus.d_plus = dp; bus.d_minus = dm; bus.bit_strobe = 1'b1;
        @(posedge clk); #1;
        bus.bit_strobe = 1'b0;
        e_sync = s; e_byte = b; e_eop = e; e_err = r;
        e_data = model_data; e_rcv = model_rcv;
        @(posedge clk); #1;
        e_sync = 1'b0; e_byte = 1'b0; e_eop = 1'b0; e_err = 1'b0;
        @(posedge clk);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it
    task automatic send_bit(input bit b, input bit s, input bit byt, input bit r);
        if (!b) lvl = ~lvl;
        line(lvl, ~lvl, s, byt, 1'b0, r);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        for (int i = 0; i < n; i++) line(1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic send_sync(input logic [7:0] pat);
        model_rcv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && pat != 8'h80) model_rcv = 1'b0;
            send_bit(pat[i], (i == 7) && (pat == 8'h80), 0, 0);
        end
        run = 0;
    endtask

    // First n bits of a byte, LSB first, with a 0 inserted after every six 1s
    task automatic send_data(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 7) model_data = b;
            send_bit(b[i], 0, i == 7, 0);
            if (b[i]) run++; else run = 0;
            if (run == 6) begin
                send_bit(1'b0, 0, 0, 0);
                run = 0;
            end
        end
    endtask

    task automatic send_eop(input bit partial);
        line(1'b0, 1'b0, 0, 0, 0, 0);
        line(1'b0, 1'b0, 0, 0, 0, 0);
        model_rcv = 1'b0;
        line(1'b1, 1'b0, 0, 0, 1, partial);
        lvl = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        bus.bit_strobe = 1'b0;
        @(posedge clk); #1;
        model_data = 8'h00; model_rcv = 1'b0;
        e_data = 8'h00; e_rcv = 1'b0;
        e_sync = 1'b0; e_byte = 1'b0; e_eop = 1'b0; e_err = 1'b0;
        @(negedge clk);
        chk("rst_rcv_data", bus.rcv_data, 8'h00);
        chk("rst_rcving", bus.rcving, 1'b0);
        n_rst = 1'b1;
        lvl = 1'b1;
        run = 0;
    endtask

    initial begin
        n_rst = 1'b0;
        bus.d_plus = 1'b1; bus.d_minus = 1'b0; bus.bit_strobe = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("init_rcv_data", bus.rcv_data, 8'h00);
        chk("init_pulses", {bus.sync_found, bus.byte_rcvd, bus.eop, bus.rx_err, bus.rcving}, 5'b0);
        n_rst = 1'b1;

        // Basic packet carrying 0xA5
        clr_counts();
        idle(3);
        send_sync(8'h80);
        send_data(8'hA5, 8);
        send_eop(1'b0);
        idle(1);
        chk("a5_data", bus.rcv_data, 8'hA5);
        chk("a5_sync_cnt", c_sync, 1);
        chk("a5_byte_cnt", c_byte, 1);
        chk("a5_eop_cnt", c_eop, 1);
        chk("a5_err_cnt", c_err, 0);
        chk("a5_rcving", bus.rcving, 1'b0);

        // 0xFF needs a stuffed 0 after the sixth 1
        clr_counts();
        send_sync(8'h80);
        send_data(8'hFF, 8);
        send_eop(1'b0);
        idle(1);
        chk("ff_data", bus.rcv_data, 8'hFF);
        chk("ff_byte_cnt", c_byte, 1);
        chk("ff_err_cnt", c_err, 0);

        // Seven 1s in a row: stuff violation, then SE0,J returns to idle silently
        clr_counts();
        send_sync(8'h80);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 0, 0, 0);
        send_bit(1'b1, 0, 0, 1);
        chk("stuff_err_rcving", bus.rcving, 1'b1);
        line(1'b0, 1'b0, 0, 0, 0, 0);
        model_rcv = 1'b0;
        line(1'b1, 1'b0, 0, 0, 0, 0);
        lvl = 1'b1;
        idle(1);
        chk("stuff_err_cnt", c_err, 1);
        chk("stuff_eop_cnt", c_eop, 0);

        // Sync pattern with the wrong last bits is rejected
        clr_counts();
        send_sync(8'hC0);
        idle(2);
        chk("badsync_cnt", c_sync, 0);
        chk("badsync_rcving", bus.rcving, 1'b0);

        // Two bytes back to back, then a partial byte before EOP
        clr_counts();
        send_sync(8'h80);
        send_data(8'h3F, 8);
        send_data(8'hFC, 8);
        send_data(8'h0A, 4);
        send_eop(1'b1);
        idle(1);
        chk("partial_byte_cnt", c_byte, 2);
        chk("partial_eop_cnt", c_eop, 1);
        chk("partial_err_cnt", c_err, 1);
        chk("partial_data", bus.rcv_data, 8'hFC);

        // Reset in the middle of a data byte, then a fresh packet
        clr_counts();
        send_sync(8'h80);
        send_data(8'h5A, 5);
        do_reset();
        idle(2);
        send_sync(8'h80);
        send_data(8'h3C, 8);
        send_eop(1'b0);
        idle(1);
        chk("rst_eop_cnt", c_eop, 1);
        chk("rst_err_cnt", c_err, 0);
        chk("rst_fresh_data", bus.rcv_data, 8'h3C);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
